// File: rtl/uart_rx_block.sv
// 8N1 UART receiver that assembles 2*BYTES little-endian bytes into operands A and B
// and pulses o_done once per complete pair.
module uart_rx_block #(
    parameter int SIZE_DATA      = 32,
    parameter int BAUDRATE_VALUE = 325
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx_en,
    input  logic                 i_rx_data,
    output logic [SIZE_DATA-1:0] o_data_a,
    output logic [SIZE_DATA-1:0] o_data_b,
    output logic                 o_done
);

    localparam int BYTES = SIZE_DATA / 8;
    localparam int CNT_W = $clog2(BAUDRATE_VALUE);
    localparam int IDX_W = $clog2(2 * BYTES);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(BAUDRATE_VALUE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(BAUDRATE_VALUE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [2:0]           bit_cnt_r;
    logic [7:0]           shift_r;
    logic [IDX_W-1:0]     byte_idx_r;
    logic [SIZE_DATA-1:0] stage_a_r;
    logic [SIZE_DATA-1:0] stage_b_r;
    logic [SIZE_DATA-1:0] stage_a_nxt_s;
    logic [SIZE_DATA-1:0] stage_b_nxt_s;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_s;

    assign rx_s = rx_sync_r;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= i_rx_data;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Staging words with the just-received byte merged into its lane, so the final
    // byte can be copied straight to the outputs on the accepting edge.
    always_comb begin
        stage_a_nxt_s = stage_a_r;
        stage_b_nxt_s = stage_b_r;
        for (int i = 0; i < BYTES; i++) begin
            stage_a_nxt_s[8*i +: 8] = (byte_idx_r == IDX_W'(i)) ? shift_r : stage_a_r[8*i +: 8];
            stage_b_nxt_s[8*i +: 8] = (byte_idx_r == IDX_W'(i + BYTES)) ? shift_r : stage_b_r[8*i +: 8];
        end
    end

    // Frame FSM, byte assembly and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
            byte_idx_r <= '0;
            stage_a_r  <= '0;
            stage_b_r  <= '0;
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (!i_rx_en) begin
                state_r    <= IDLE;
                cnt_r      <= '0;
                byte_idx_r <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (!rx_s) begin
                            cnt_r   <= '0;
                            state_r <= START;
                        end
                    end
                    START: begin
                        if (cnt_r == HALF_M1) begin
                            cnt_r     <= '0;
                            bit_cnt_r <= 3'd0;
                            state_r   <= rx_s ? IDLE : DATA;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (cnt_r == FULL_M1) begin
                            cnt_r     <= '0;
                            shift_r   <= {rx_s, shift_r[7:1]};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                state_r <= STOP;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (cnt_r == FULL_M1) begin
                            cnt_r   <= '0;
                            state_r <= IDLE;
                            // A low stop bit is a framing error: drop the byte, keep the index.
                            if (rx_s) begin
                                stage_a_r <= stage_a_nxt_s;
                                stage_b_r <= stage_b_nxt_s;
                                if (byte_idx_r == LAST_IDX) begin
                                    o_data_a   <= stage_a_nxt_s;
                                    o_data_b   <= stage_b_nxt_s;
                                    o_done     <= 1'b1;
                                    byte_idx_r <= '0;
                                end else begin
                                    byte_idx_r <= byte_idx_r + IDX_W'(1);
                                end
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_block.sv
// Self-checking bench: bit-level transmitter, byte-list reference model and a
// scoreboard monitor that checks every o_done pulse.
module tb_uart_rx_block;

    localparam int SIZE_DATA = 32;
    localparam int BAUD      = 20;
    localparam int BYTES     = SIZE_DATA / 8;
    localparam int HALF      = BAUD / 2;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 i_rx_en;
    logic                 i_rx_data;
    logic [SIZE_DATA-1:0] o_data_a;
    logic [SIZE_DATA-1:0] o_data_b;
    logic                 o_done;

    int errors    = 0;
    int checks    = 0;
    int done_seen = 0;
    int done_exp  = 0;

    logic [SIZE_DATA-1:0] exp_a_q[$];
    logic [SIZE_DATA-1:0] exp_b_q[$];
    logic [7:0]           acc_q[$];
    logic [SIZE_DATA-1:0] shown_a = '0;
    logic [SIZE_DATA-1:0] shown_b = '0;

    always #5 i_clk = ~i_clk;

    uart_rx_block #(
        .SIZE_DATA      (SIZE_DATA),
        .BAUDRATE_VALUE (BAUD)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_rx_en   (i_rx_en),
        .i_rx_data (i_rx_data),
        .o_data_a  (o_data_a),
        .o_data_b  (o_data_b),
        .o_done    (o_done)
    );

    task automatic check(input string name, input logic [SIZE_DATA-1:0] act, input logic [SIZE_DATA-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a receiver enabled for the whole byte keeps every byte with a good
    // stop bit; every 2*BYTES kept bytes form one pair, little-endian.
    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        logic [SIZE_DATA-1:0] ea;
        logic [SIZE_DATA-1:0] eb;
        if (i_rx_en && stop_ok) begin
            acc_q.push_back(b);
            if (acc_q.size() == 2 * BYTES) begin
                for (int i = 0; i < BYTES; i++) begin
                    ea[8*i +: 8] = acc_q[i];
                    eb[8*i +: 8] = acc_q[BYTES + i];
                end
                exp_a_q.push_back(ea);
                exp_b_q.push_back(eb);
                done_exp++;
                acc_q.delete();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_bit, input int gap_bits);
        model_byte(b, stop_bit);
        i_rx_data = 1'b0;
        repeat (BAUD) @(negedge i_clk);
        for (int i = 0; i < 8; i++) begin
            i_rx_data = b[i];
            repeat (BAUD) @(negedge i_clk);
        end
        i_rx_data = stop_bit;
        repeat (BAUD) @(negedge i_clk);
        i_rx_data = 1'b1;
        repeat (gap_bits * BAUD) @(negedge i_clk);
        check("hold_a", o_data_a, shown_a);
        check("hold_b", o_data_b, shown_b);
    endtask

    task automatic send_list(input logic [63:0] bytes_le, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(bytes_le[8*i +: 8], 1'b1, 0);
        end
    endtask

    task automatic set_en(input logic v);
        i_rx_en = v;
        if (!v) begin
            acc_q.delete();
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        acc_q.delete();
        repeat (3) @(negedge i_clk);
        check("rst_a", o_data_a, '0);
        check("rst_b", o_data_b, '0);
        check("rst_done", {31'd0, o_done}, '0);
        shown_a = '0;
        shown_b = '0;
        i_rst   = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected pair.
    always @(negedge i_clk) begin : monitor
        logic [SIZE_DATA-1:0] ea;
        logic [SIZE_DATA-1:0] eb;
        if (i_rst === 1'b0 && o_done === 1'b1) begin
            done_seen++;
            if (exp_a_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with a=%h b=%h, expected no pulse", o_data_a, o_data_b);
            end else begin
                ea = exp_a_q.pop_front();
                eb = exp_b_q.pop_front();
                check("done_a", o_data_a, ea);
                check("done_b", o_data_b, eb);
                shown_a = ea;
                shown_b = eb;
            end
        end
    end

    initial begin
        int d0;
        i_rst     = 1'b1;
        i_rx_en   = 1'b1;
        i_rx_data = 1'b1;
        do_reset();

        // Repeated pattern; no pulse after the first operand
        send_list(64'hC0B0C0A6, 4);
        check("no_done_after_4", done_seen, 0);
        send_list(64'hC0B0C0A6, 4);
        check("t1_a", o_data_a, 32'hC0B0C0A6);
        check("t1_b", o_data_b, 32'hC0B0C0A6);
        check("t1_count", done_seen, 1);

        // Two pairs back to back, outputs held in between
        send_list(64'h40000000_3F800000, 8);
        check("t2_a", o_data_a, 32'h3F800000);
        check("t2_b", o_data_b, 32'h40000000);
        send_list(64'h08070605_04030201, 8);
        check("t2b_a", o_data_a, 32'h04030201);
        check("t2b_b", o_data_b, 32'h08070605);

        // Short start glitches are rejected
        for (int g = 0; g < 3; g++) begin
            i_rx_data = 1'b0;
            repeat ((g == 0) ? HALF - 3 : $urandom_range(1, HALF - 3)) @(negedge i_clk);
            i_rx_data = 1'b1;
            repeat (2 * BAUD) @(negedge i_clk);
        end
        d0 = done_seen;
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1, 0);
        check("glitch_count", done_seen, d0 + 1);

        // Framing error in byte 3 is excluded
        d0 = done_seen;
        send_byte(8'h11, 1'b1, 0);
        send_byte(8'h22, 1'b1, 0);
        send_byte(8'hEE, 1'b0, 2);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h33 + 8'(i)), 1'b1, 0);
        check("frame_no_done", done_seen, d0);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h90 + 8'(i)), 1'b1, 0);
        check("frame_done", done_seen, d0 + 1);

        // Reset mid-pair drops the partial pair
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1, 0);
        do_reset();
        d0 = done_seen;
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1, 0);
        check("reset_recover", done_seen, d0 + 1);

        // Disabled receiver ignores traffic; disabling clears the byte index
        d0 = done_seen;
        set_en(1'b0);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1, 0);
        check("disabled_no_done", done_seen, d0);
        set_en(1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 0);
        set_en(1'b0);
        repeat (3) @(negedge i_clk);
        set_en(1'b1);
        repeat (3) @(negedge i_clk);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1, 0);
        check("reenable_done", done_seen, d0 + 1);

        // Random traffic with gaps and occasional framing errors
        for (int i = 0; i < 48; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                send_byte(8'($urandom), 1'b0, 2);
            end else begin
                send_byte(8'($urandom), 1'b1, $urandom_range(0, 2));
            end
        end

        repeat (2 * BAUD) @(negedge i_clk);
        check("pending_pairs", exp_a_q.size(), 0);
        check("done_total", done_seen, done_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_block.md
# uart_rx_block

UART receiver that turns an 8N1 serial byte stream into two SIZE_DATA-bit operands, A and B, for the floating-point datapath. Eight consecutive bytes (for SIZE_DATA=32) arrive least-significant byte first: the first four form operand A and the next four form operand B. After the last byte, both operands are presented together and a one-cycle done pulse is issued. It sits between the board RX pin (driven by the matching UART transmitter at the same baud divisor) and the FP unit's operand inputs.

## Interface
- SIZE_DATA, 32: operand width in bits; must be a multiple of 8; BYTES = SIZE_DATA/8 bytes per operand.
- BAUDRATE_VALUE, 325: clock cycles per serial bit; must match the transmitter; minimum 8.
- i_clk  in  1  single system clock; all logic on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_rx_en  in  1  receive enable; low forces idle.
- i_rx_data  in  1  serial line; idles high; asynchronous to i_clk.
- o_data_a  out  SIZE_DATA  operand A (first BYTES bytes, little-endian).
- o_data_b  out  SIZE_DATA  operand B (next BYTES bytes, little-endian).
- o_done  out  1  one-cycle pulse when a new A/B pair is valid.

## Operation
- i_rx_data passes through a 2-flop synchronizer; the synchronizer flops reset to 1. All decisions use the synchronized value, rx_s.
- Frame format is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). There is no parity.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: when i_rx_en=1 and rx_s=0, clear the bit-period counter and go to START.
  - START: count BAUDRATE_VALUE/2 cycles (floor). If rx_s is still 0, clear the counter and go to DATA. Otherwise treat it as a glitch and return to IDLE.
  - DATA: every BAUDRATE_VALUE cycles, sample rx_s into the byte shift register, LSB first. After 8 samples, go to STOP.
  - STOP: after BAUDRATE_VALUE cycles, sample rx_s.
    - If rx_s=1, the byte is accepted.
    - If rx_s=0, it is a framing error: discard the byte and do not advance the byte index.
    - Either way, return to IDLE.
- Each accepted byte goes to byte index k, where k runs from 0 to 2·BYTES−1.
  - For k < BYTES, write staging A[8k+7:8k].
  - Otherwise, write staging B[8(k−BYTES)+7:8(k−BYTES)].
- When index 2·BYTES−1 is accepted:
  - Copy staging A and staging B into o_data_a and o_data_b on the same edge.
  - Pulse o_done for exactly 1 cycle.
  - Wrap the index to 0.
- o_data_a and o_data_b hold their values between done pulses. They never show partially assembled words.
- i_rx_en=0 has these effects:
  - The FSM returns to IDLE immediately, aborting any partial frame.
  - The byte index clears to 0.
  - Staging registers are not cleared, since they are overwritten anyway.
  - Outputs hold.
- The next start bit is accepted from IDLE on the cycle after STOP completes. Back-to-back frames with no idle gap must be received.

## Timing
- Reset values:
  - o_data_a = 0, o_data_b = 0, o_done = 0.
  - FSM in IDLE, byte index 0, staging registers 0, synchronizer 1.
- Reset asserted mid-frame aborts it immediately. The partial pair is lost, and reception restarts at byte 0 after release.
- Bit sampling: data bit n (n = 0..7) is sampled BAUDRATE_VALUE/2 + (n+1)·BAUDRATE_VALUE cycles after the START entry edge, i.e. at mid-bit. The stop bit is sampled at + 9·BAUDRATE_VALUE.
- o_done latency is 1 cycle after the stop-bit sample of the last byte.
  - The total from the final stop bit's leading edge on the pin is about BAUDRATE_VALUE/2 + 4 cycles, including the 2-cycle synchronizer.
- A start glitch shorter than BAUDRATE_VALUE/2 cycles is rejected.
- Tolerated baud mismatch is at least ±3% with the mid-bit sampling.
- Simultaneous events: if i_rx_en falls on the same cycle as the final stop-bit sample, i_rx_en wins. No o_done is issued and the index clears.

## Test plan
- Matching transmitter (BAUDRATE_VALUE=325, 10 ns clock) sends bytes A6 C0 B0 C0 A6 C0 B0 C0 -> exactly one o_done pulse, with o_data_a=o_data_b=32'hC0B0C0A6. There is no o_done after byte 4.
- Bytes 00 00 80 3F 00 00 00 40 followed by a second pair 01 02 03 04 05 06 07 08 -> first pulse gives a=32'h3F800000, b=32'h40000000. Second pulse gives a=32'h04030201, b=32'h08070605, and outputs hold between pulses.
- 100-cycle low glitch on the idle line, then 8 valid bytes -> no extra byte is counted and a single o_done pulse carries the correct values.
- Byte 3 sent with its stop bit 0, then 5 valid bytes -> no o_done. Sending 3 more valid bytes then completes the pair with the framing-error byte excluded.
- Reset asserted after byte 5 of a pair, released, then a full 8-byte pair -> all outputs are 0 during reset, then the new pair appears correctly.
- i_rx_en=0 while 8 bytes are transmitted -> no o_done and outputs unchanged. Re-enable and send 8 bytes -> correct pair.
